// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage of the multi-cycle RV32I core.
//
// Owns the PC and runs one instruction-memory read per instruction using a
// req/gnt/rvalid handshake. The returned word is latched into the instruction
// register (IR), whose decoded fields drive the control unit. When the
// control unit signals end of instruction (pc_upd), the next PC is committed:
// either the sequential PC or a taken conditional-branch target.
//
// A taken branch to a target that is not word aligned raises a sticky fault.
// The PC is then frozen, and the unit does nothing more until reset.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   fetch_en         start a fetch (sampled only in IDLE)
//   pc_upd           end-of-instruction strobe (sampled only in HOLD)
//   branch, zero     branch control and ALU zero flag for next-PC selection
//   imem_req/addr    read request and address (address is always pc)
//   imem_gnt         request accepted this cycle
//   imem_rvalid/data read response
//   instr            instruction register
//   instr_valid      IR holds a fetched, not yet retired instruction
//   opcode/func3/func7b5  combinational fields of instr
//   pc               current PC
//   busy             fetch in flight (REQ or WAIT)
//   fault            sticky misaligned-branch-target fault

module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic            pc_upd,
  input  logic            branch,
  input  logic            zero,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic            func7b5,
  output logic [XLEN-1:0] pc,
  output logic            busy,
  output logic            fault
);

  localparam logic [31:0] InstrNop     = 32'h0000_0013;
  localparam logic [6:0]  OpcodeBranch = 7'b1100011;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StFault
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            fault_q, fault_d;
  logic            imem_req_q, imem_req_d;
  logic            busy_q, busy_d;

  // Next-PC datapath
  logic            take;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] seq_pc;
  logic            misaligned;

  assign opcode  = instr_q[6:0];
  assign func3   = instr_q[14:12];
  assign func7b5 = instr_q[30];

  assign take  = branch & zero & (opcode == OpcodeBranch);
  // B-type immediate: 13-bit signed, always even, sign-extended to XLEN.
  assign imm_b = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                  instr_q[11:8], 1'b0};
  assign branch_target = pc_q + imm_b;
  assign seq_pc        = pc_q + XLEN'(4);
  // Bit 0 of the target is always clear, so bit 1 alone decides alignment.
  assign misaligned    = take & branch_target[1];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;

    unique case (state_q)
      StIdle: begin
        if (fetch_en) begin
          state_d = StReq;
        end
      end

      StReq: begin
        if (imem_gnt) begin
          if (imem_rvalid) begin
            // Zero-wait memory: response arrives with the grant.
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = StHold;
          end else begin
            state_d = StWait;
          end
        end
      end

      StWait: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = StHold;
        end
      end

      StHold: begin
        // fetch_en is dropped here; the control unit re-requests later.
        if (pc_upd) begin
          instr_valid_d = 1'b0;
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = StFault;
          end else begin
            pc_d    = take ? branch_target : seq_pc;
            state_d = StIdle;
          end
        end
      end

      StFault: begin
        instr_valid_d = 1'b0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Request and busy are registered from the next state so they line up
  // with the state they describe.
  always_comb begin
    imem_req_d = (state_d == StReq);
    busy_d     = (state_d == StReq) || (state_d == StWait);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= InstrNop;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      imem_req_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      imem_req_q    <= imem_req_d;
      busy_q        <= busy_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign fault       = fault_q;

endmodule
